// File: rtl/write_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : write_buffer_pkg
// Brief    : Shared types and constants for the ping-pong pixel write buffer.
// Revision : 1.0
// ============================================================================
package write_buffer_pkg;

  localparam int AVALON_DW = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/pingpong_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_write_buffer_if
// Brief    : Pixel-in / Avalon-MM write-out bundle of the ping-pong buffer.
// Revision : 1.0
// ============================================================================
interface pingpong_write_buffer_if #(
  parameter int PIXEL_W = 24
);

  logic [PIXEL_W-1:0]                      f_pixel;
  logic                                    pixel_done;
  logic                                    flush;
  logic                                    pixel_ready;
  logic                                    overflow;
  logic                                    master_waitrequest;
  logic                                    master_writeresponsevalid;
  logic                                    master_write;
  logic [write_buffer_pkg::AVALON_DW-1:0]  master_writedata;
  logic                                    done_write;

  modport slave (
    input  f_pixel, pixel_done, flush, master_waitrequest, master_writeresponsevalid,
    output master_write, master_writedata, pixel_ready, overflow, done_write
  );

  modport master (
    output f_pixel, pixel_done, flush, master_waitrequest, master_writeresponsevalid,
    input  master_write, master_writedata, pixel_ready, overflow, done_write
  );

endinterface
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module   : flex_counter
// Brief    : Up counter with synchronous clear and programmable rollover.
// Revision : 1.0
// ============================================================================
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  localparam logic [NUM_CNT_BITS-1:0] c_one = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_CNT_BITS-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (clear)
      w_count_next = '0;
    else if (count_enable)
      w_count_next = (r_count == rollover_val) ? c_one : r_count + c_one;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_count <= '0;
    else        r_count <= w_count_next;
  end

  assign count_out = r_count;

endmodule
`default_nettype wire

// File: rtl/pingpong_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_write_buffer
// Brief    : Two-bank pixel collector draining full banks as Avalon-MM writes.
// Revision : 1.0
// ============================================================================
module pingpong_write_buffer
  import write_buffer_pkg::*;
#(
  parameter int PIXEL_W = 24,
  parameter int DEPTH   = 6
) (
  input  logic                     clk,
  input  logic                     n_rst,
  pingpong_write_buffer_if.slave   bus
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   c_depth = CW'(DEPTH);
  localparam logic [CW-1:0]   c_one   = CW'(1);

  logic [PIXEL_W-1:0] r_mem [2][DEPTH];
  logic [CW-1:0]      r_len [2];
  logic [1:0]         r_full;
  logic               r_fill_bank, r_drain_bank;
  logic               r_pixel_ready, r_overflow, r_done_write;
  logic [CW-1:0]      r_issue_idx, r_resp_cnt;
  drain_state_t       r_state, w_state_next;

  logic [CW-1:0]      w_fill_idx, w_close_len, w_drain_len;
  logic [CW-1:0]      w_issue_idx_next, w_resp_cnt_next;
  logic               w_store, w_close, w_complete, w_write;
  logic [1:0]         w_full_next;

  // Flush and a same-cycle pixel close the bank together, so length counts that pixel.
  assign w_store     = bus.pixel_done & r_pixel_ready;
  assign w_close_len = w_fill_idx + CW'(w_store);
  assign w_close     = r_pixel_ready &
                       ((w_store & (w_close_len == c_depth)) | (bus.flush & (w_close_len != '0)));
  assign w_drain_len = r_len[r_drain_bank];

  flex_counter #(.NUM_CNT_BITS(CW)) u_fill_idx (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_close),
    .count_enable (w_store),
    .rollover_val (c_depth),
    .count_out    (w_fill_idx)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    w_issue_idx_next = r_issue_idx;
    w_resp_cnt_next  = r_resp_cnt;
    w_complete       = 1'b0;
    w_write          = 1'b0;
    case (r_state)
      IDLE: begin
        w_resp_cnt_next = '0;
        if (r_full[r_drain_bank]) w_state_next = ISSUE;
      end
      ISSUE: begin
        w_write         = 1'b1;
        w_resp_cnt_next = r_resp_cnt + CW'(bus.master_writeresponsevalid);
        if (!bus.master_waitrequest) begin
          if (r_issue_idx == w_drain_len - c_one) begin
            w_issue_idx_next = '0;
            w_state_next     = WAIT_RESP;
          end else begin
            w_issue_idx_next = r_issue_idx + c_one;
          end
        end
      end
      WAIT_RESP: begin
        w_resp_cnt_next = r_resp_cnt + CW'(bus.master_writeresponsevalid);
        if (w_resp_cnt_next == w_drain_len) begin
          w_complete      = 1'b1;
          w_resp_cnt_next = '0;
          w_state_next    = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Fill and drain never target the same bank when a close and a free coincide.
  always_comb begin
    w_full_next = r_full;
    if (w_close)    w_full_next[r_fill_bank]  = 1'b1;
    if (w_complete) w_full_next[r_drain_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int b = 0; b < 2; b++) begin
        r_len[b] <= '0;
        for (int i = 0; i < DEPTH; i++) r_mem[b][i] <= '0;
      end
      r_full        <= '0;
      r_fill_bank   <= 1'b0;
      r_drain_bank  <= 1'b0;
      r_pixel_ready <= 1'b1;
      r_overflow    <= 1'b0;
      r_done_write  <= 1'b0;
      r_issue_idx   <= '0;
      r_resp_cnt    <= '0;
    end else begin
      if (w_store) r_mem[r_fill_bank][w_fill_idx] <= bus.f_pixel;
      if (w_close) begin
        r_len[r_fill_bank] <= w_close_len;
        r_fill_bank        <= ~r_fill_bank;
      end
      if (w_complete) r_drain_bank <= ~r_drain_bank;
      r_full        <= w_full_next;
      r_pixel_ready <= ~&w_full_next;
      r_overflow    <= bus.pixel_done & ~r_pixel_ready;
      r_done_write  <= w_complete;
      r_issue_idx   <= w_issue_idx_next;
      r_resp_cnt    <= w_resp_cnt_next;
    end
  end

  assign bus.master_write     = w_write;
  assign bus.master_writedata = w_write ? AVALON_DW'(r_mem[r_drain_bank][r_issue_idx]) : '0;
  assign bus.pixel_ready      = r_pixel_ready;
  assign bus.overflow         = r_overflow;
  assign bus.done_write       = r_done_write;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pingpong_write_buffer
// Brief    : Scoreboard bench for the ping-pong pixel write buffer.
// Revision : 1.0
// ============================================================================
module tb_pingpong_write_buffer;

  localparam int PIXEL_W = 24;
  localparam int DEPTH   = 6;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  pingpong_write_buffer_if #(.PIXEL_W(PIXEL_W)) bus ();

  pingpong_write_buffer #(.PIXEL_W(PIXEL_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  logic [31:0] exp_q [$];
  int          resp_q [$];
  int          resp_delay   = 1;
  bit          resp_en      = 1'b1;
  int          done_cnt     = 0;
  int          ovf_cnt      = 0;
  int          wr_cnt       = 0;
  int          extra_wr     = 0;
  int          last_wr_cyc  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observe accepted writes and output pulses on the falling edge.
  initial forever begin
    @(negedge clk);
    if (n_rst) begin
      if (bus.done_write) done_cnt++;
      if (bus.overflow)   ovf_cnt++;
      if (bus.master_write && !bus.master_waitrequest) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        resp_q.push_back(cyc + resp_delay);
        if (exp_q.size() > 0) check("wdata", bus.master_writedata, exp_q.pop_front());
        else                  extra_wr++;
      end
      if (!bus.master_write) check("wdata_idle", bus.master_writedata, 32'h0);
    end
  end

  initial begin
    bus.master_writeresponsevalid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en && resp_q.size() > 0 && resp_q[0] <= cyc) begin
        void'(resp_q.pop_front());
        bus.master_writeresponsevalid = 1'b1;
      end else begin
        bus.master_writeresponsevalid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pixel(input logic [PIXEL_W-1:0] pix, input bit fl, input bit stored);
    bus.f_pixel    = pix;
    bus.pixel_done = 1'b1;
    bus.flush      = fl;
    if (stored) exp_q.push_back(32'(pix));
    @(posedge clk);
    #1;
    bus.pixel_done = 1'b0;
    bus.flush      = 1'b0;
    bus.f_pixel    = '0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic clear_counts();
    done_cnt = 0;
    ovf_cnt  = 0;
    wr_cnt   = 0;
    extra_wr = 0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("done_count", done_cnt, target);
  endtask

  // Returns the cycle in which master_write is first seen high, or -1 on timeout.
  task automatic wait_write(output int at_cyc);
    int k = 0;
    at_cyc = -1;
    while (k < 20 && at_cyc < 0) begin
      @(negedge clk);
      if (bus.master_write) at_cyc = cyc;
      k++;
    end
    check("write_seen", at_cyc >= 0, 1'b1);
  endtask

  task automatic end_test(input string tag, input int writes);
    check({tag, "_writes"}, wr_cnt, writes);
    check({tag, "_extra"}, extra_wr, 0);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic basic_burst(input string tag);
    int last_pix;
    int first_wr;
    clear_counts();
    resp_delay = 1;
    for (int i = 1; i <= 6; i++) send_pixel(PIXEL_W'(i), 1'b0, 1'b1);
    last_pix = cyc;
    wait_write(first_wr);
    // Last pixel_done was presented in cycle last_pix-1; write rises two cycles later.
    check({tag, "_latency"}, first_wr, last_pix - 1 + 2);
    @(posedge clk);
    #1;
    wait_done(1, 100);
    check({tag, "_span"}, last_wr_cyc - first_wr, 5);
    end_test(tag, 6);
  endtask

  initial begin
    int first_wr;
    bus.f_pixel            = '0;
    bus.pixel_done         = 1'b0;
    bus.flush              = 1'b0;
    bus.master_waitrequest = 1'b0;
    idle(2);
    check("rst_write", bus.master_write, 1'b0);
    check("rst_wdata", bus.master_writedata, 32'h0);
    check("rst_done", bus.done_write, 1'b0);
    check("rst_ovf", bus.overflow, 1'b0);
    check("rst_ready", bus.pixel_ready, 1'b1);
    n_rst = 1'b1;
    idle(2);

    basic_burst("basic");

    // Back-pressure: stall the second write for three cycles.
    clear_counts();
    for (int i = 1; i <= 6; i++) send_pixel(PIXEL_W'(i), 1'b0, 1'b1);
    wait_write(first_wr);
    @(posedge clk);
    #1;
    bus.master_waitrequest = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", bus.master_writedata, 32'h2);
    end
    @(posedge clk);
    #1;
    bus.master_waitrequest = 1'b0;
    wait_done(1, 100);
    end_test("bp", 6);

    // Ping-pong: bank 1 fills while bank 0 drains with slow responses.
    clear_counts();
    resp_delay = 10;
    for (int i = 1; i <= 12; i++) begin
      check("pp_ready", bus.pixel_ready, 1'b1);
      send_pixel(PIXEL_W'(24'h000100 + i), 1'b0, 1'b1);
    end
    wait_done(2, 300);
    end_test("pp", 12);

    // Overflow: no responses, so both banks stay occupied after pixel 12.
    clear_counts();
    resp_delay = 1;
    resp_en    = 1'b0;
    for (int i = 1; i <= 12; i++) send_pixel(PIXEL_W'(24'h000200 + i), 1'b0, 1'b1);
    check("ovf_ready_low", bus.pixel_ready, 1'b0);
    send_pixel(24'h00020D, 1'b0, 1'b0);
    idle(3);
    check("ovf_pulse", ovf_cnt, 1);
    resp_en = 1'b1;
    wait_done(2, 300);
    check("ovf_ready_back", bus.pixel_ready, 1'b1);
    check("ovf_pulse_final", ovf_cnt, 1);
    end_test("ovf", 12);

    // Flush of a partial bank, then flush of an empty bank.
    clear_counts();
    resp_delay = 2;
    for (int i = 1; i <= 3; i++) send_pixel(PIXEL_W'(24'h000300 + i), 1'b0, 1'b1);
    do_flush();
    wait_done(1, 100);
    end_test("flush", 3);
    clear_counts();
    do_flush();
    idle(20);
    check("flush_empty_done", done_cnt, 0);
    end_test("flush_empty", 0);

    // Flush together with the last pixel includes that pixel.
    clear_counts();
    send_pixel(24'h000401, 1'b0, 1'b1);
    send_pixel(24'h000402, 1'b0, 1'b1);
    send_pixel(24'h000403, 1'b1, 1'b1);
    wait_done(1, 100);
    end_test("flush_pix", 3);

    // Asynchronous reset in the middle of issuing.
    clear_counts();
    for (int i = 1; i <= 6; i++) send_pixel(PIXEL_W'(24'h000500 + i), 1'b0, 1'b1);
    wait_write(first_wr);
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_rst_write", bus.master_write, 1'b0);
    check("mid_rst_wdata", bus.master_writedata, 32'h0);
    check("mid_rst_ready", bus.pixel_ready, 1'b1);
    check("mid_rst_done", bus.done_write, 1'b0);
    exp_q.delete();
    resp_q.delete();
    @(posedge clk);
    #1;
    idle(1);
    n_rst = 1'b1;
    idle(2);
    basic_burst("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pingpong_write_buffer.md
# pingpong_write_buffer

Parametrised ping-pong pixel write buffer between the cartoonifier filter pipeline and the Avalon-MM write master. Filtered pixels are collected into two alternating banks of DEPTH entries. A full bank is drained as zero-extended 32-bit writes with proper `master_waitrequest` back-pressure, while the other bank keeps filling. The block adds what the single-burst buffer lacked: configurable width and depth, an upstream ready signal, overflow reporting, and a flush for short final bursts.

## Interface
- `PIXEL_W`, 24, pixel width in bits; must be ≤ 32.
- `DEPTH`, 6, pixels per bank (burst length); must be ≥ 2.
- `clk` in 1: system clock.
- `n_rst` in 1: asynchronous, active-low reset.
- `f_pixel` in PIXEL_W: filtered pixel, valid while `pixel_done` is high.
- `pixel_done` in 1: single-cycle pixel strobe.
- `flush` in 1: close the partially filled fill bank so it drains now.
- `master_waitrequest` in 1: Avalon stall; the write is held while high.
- `master_writeresponsevalid` in 1: one pulse per completed write.
- `master_write` out 1: Avalon write request.
- `master_writedata` out 32: `{zeros, pixel}`.
- `pixel_ready` out 1: high when a `pixel_done` this cycle will be stored.
- `overflow` out 1: one-cycle pulse when a pixel is dropped.
- `done_write` out 1: one-cycle pulse when a bank's final response arrives.

## Operation
- **Bank roles**
  - Bank 0 fills first.
  - Fill and drain roles alternate strictly (0, 1, 0, …).
  - Drain order equals fill order.
  - Within a bank, entry 0 (the oldest pixel) is written first.
- **Fill side**
  - A `pixel_done` with `pixel_ready` high stores `f_pixel` at the fill index and increments it.
  - When the index reaches DEPTH, the bank is marked full with length DEPTH, the fill role passes to the other bank, and the index clears.
- **Flush**
  - With fill count k > 0, the bank is marked full with length k.
  - With k = 0, flush is a no-op.
  - `flush` together with `pixel_done` in the same cycle includes that pixel (length k+1).
- **Ready and overflow**
  - `pixel_ready` = 0 only while both banks are full or draining.
  - `pixel_done` while `pixel_ready` = 0 drops the pixel and pulses `overflow`.
  - `flush` is ignored in that case.
- **Drain FSM** (`IDLE`, `ISSUE`, `WAIT_RESP`)
  - `IDLE`: move to `ISSUE` when the drain bank is full.
  - `ISSUE`: `master_write` = 1 and `master_writedata` = entry at the issue index. The index advances only in cycles with `master_waitrequest` = 0. After the last entry (index = length − 1) is accepted, move to `WAIT_RESP`.
  - `WAIT_RESP`: wait until the response count equals the length. Then pulse `done_write`, free the bank, flip the drain pointer and return to `IDLE`.
- **Response counting**
  - Responses are counted in `ISSUE` as well as in `WAIT_RESP`, because responses may overlap issuing.
  - Responses arriving in `IDLE` are ignored.
- **Arithmetic**
  - Counters are `$clog2(DEPTH+1)` bits wide.
  - `master_writedata[31:PIXEL_W]` is always 0.
  - `master_writedata` = 0 whenever `master_write` = 0.

## Timing
- **Reset values**
  - `master_write` = 0, `master_writedata` = 0, `done_write` = 0, `overflow` = 0, `pixel_ready` = 1.
  - FSM in `IDLE`, fill bank 0, all counters 0, both banks empty.
- **Latency**
  - A bank is marked full on the edge after its last pixel or flush.
  - `master_write` rises 2 cycles after the last `pixel_done` (FSM state is registered).
  - With `master_waitrequest` low, one write is issued per cycle.
- **Output timing**
  - `done_write` is asserted in the cycle after the final response edge.
  - `pixel_ready` is registered and reflects freed banks from that same cycle.
- **Simultaneous events**
  - A bank freed in the same edge as a `pixel_done` with `pixel_ready` = 0: the pixel is still dropped.
- **Reset mid-burst**
  - All contents are discarded and outputs return to reset values immediately (asynchronous).

## Structure
- Package `write_buffer_pkg`: the `drain_state_t` enum and the constant `AVALON_DW = 32`.
- Sub-module: reuse `flex_counter` for the fill index, clear on bank handover, `rollover_val = DEPTH`.
- Issue and response counters are local to this block, because flush makes their terminal value variable.
- Storage: two PIXEL_W × DEPTH register arrays. No shift chains.

## Test plan
- **Basic burst:** 6 `pixel_done` strobes with pixels 0x000001–0x000006, waitrequest low, 6 responses → writes 0x00000001…0x00000006 in order on consecutive cycles; one `done_write` pulse.
- **Back-pressure:** waitrequest high for 3 cycles on the 2nd write → `master_writedata` is held at 0x00000002 for 4 cycles; no write is lost or duplicated.
- **Ping-pong:** 12 back-to-back pixels with responses delayed 10 cycles → bank 1 fills while bank 0 drains; `pixel_ready` stays 1; 12 ordered writes; 2 `done_write` pulses.
- **Overflow:** 13 pixels with no responses → `pixel_ready` falls after pixel 12; pixel 13 is dropped; `overflow` pulses once; later writes contain only pixels 1–12.
- **Flush:** 3 pixels then `flush` → exactly 3 writes, then `done_write` after 3 responses. A second `flush` with an empty bank does nothing.
- **Reset mid-burst:** `n_rst` low during `ISSUE` → `master_write` = 0 immediately. After release, a fresh 6-pixel burst behaves exactly as in the basic burst test.
